// File: rtl/uart_wb_master.sv
// UART byte-protocol to Wishbone master bridge: 'w'/'r' frames become single 32-bit bus cycles,
// answered over the UART with '.', read data, '!' on bus timeout or '?' on an unknown command.
module uart_wb_master #(
  parameter int BUS_TIMEOUT  = 1023,
  parameter int BYTE_TIMEOUT = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  output logic        rx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic        busy
);

  localparam int BUS_W  = $clog2(BUS_TIMEOUT + 1);
  localparam int BYTE_W = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [BUS_W-1:0]  BUS_LAST  = BUS_W'(BUS_TIMEOUT - 1);
  localparam logic [BUS_W-1:0]  BUS_ONE   = BUS_W'(1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTE_TIMEOUT - 1);
  localparam logic [BYTE_W-1:0] BYTE_ONE  = BYTE_W'(1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, REPLY} state_t;

  state_t              state;
  logic                is_write;
  logic [1:0]          byte_cnt;
  logic [BYTE_W-1:0]   byte_tmr;
  logic [BUS_W-1:0]    bus_tmr;
  logic [31:0]         reply_buf;
  logic [2:0]          reply_cnt;
  logic                tx_guard;
  logic                rx_take;
  logic                tx_ready;

  assign rx_take  = rx_avail & ~rx_ack & ((state == IDLE) | (state == ADDR) | (state == DATA));
  // tx_busy is ignored in the cycle after tx_wr because the UART may not have raised it yet
  assign tx_ready = ~tx_busy & ~tx_wr & ~tx_guard;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      byte_cnt  <= '0;
      byte_tmr  <= '0;
      bus_tmr   <= '0;
      reply_buf <= '0;
      reply_cnt <= '0;
      tx_guard  <= 1'b0;
      rx_ack    <= 1'b0;
      tx_data   <= '0;
      tx_wr     <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
    end else begin
      rx_ack   <= rx_take;
      tx_wr    <= 1'b0;
      tx_guard <= tx_wr;
      case (state)
        IDLE: begin
          if (rx_take) begin
            byte_cnt <= '0;
            byte_tmr <= '0;
            if (rx_data == 8'h77) begin
              is_write <= 1'b1;
              state    <= ADDR;
            end else if (rx_data == 8'h72) begin
              is_write <= 1'b0;
              state    <= ADDR;
            end else begin
              reply_buf <= {8'h3F, 24'h0};
              reply_cnt <= 3'd1;
              state     <= REPLY;
            end
          end
        end
        ADDR, DATA: begin
          if (rx_take) begin
            byte_tmr <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == ADDR) wb_adr_o <= {wb_adr_o[23:0], rx_data};
            else               wb_dat_o <= {wb_dat_o[23:0], rx_data};
            if (byte_cnt == 2'd3) begin
              if (state == ADDR && is_write) begin
                state <= DATA;
              end else begin
                state    <= BUS;
                bus_tmr  <= '0;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_sel_o <= 4'hF;
                wb_we_o  <= is_write;
              end
            end
          end else if (byte_tmr == BYTE_LAST) begin
            state <= IDLE;
          end else begin
            byte_tmr <= byte_tmr + BYTE_ONE;
          end
        end
        BUS: begin
          // an ack arriving in the expiry cycle still wins over the timeout
          if (wb_ack_i || bus_tmr == BUS_LAST) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_sel_o <= 4'h0;
            wb_we_o  <= 1'b0;
            state    <= REPLY;
            if (!wb_ack_i) begin
              reply_buf <= {8'h21, 24'h0};
              reply_cnt <= 3'd1;
            end else if (is_write) begin
              reply_buf <= {8'h2E, 24'h0};
              reply_cnt <= 3'd1;
            end else begin
              reply_buf <= wb_dat_i;
              reply_cnt <= 3'd4;
            end
          end else begin
            bus_tmr <= bus_tmr + BUS_ONE;
          end
        end
        REPLY: begin
          if (tx_ready) begin
            tx_wr     <= 1'b1;
            tx_data   <= reply_buf[31:24];
            reply_buf <= {reply_buf[23:0], 8'h00};
            reply_cnt <= reply_cnt - 3'd1;
            if (reply_cnt == 3'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
